// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n -- parametrised round-robin arbiter with bounded hold time.
//
// An owner is registered and keeps its grant while it keeps requesting.
// A busy owner is forced off after MAX_HOLD granted cycles if anyone else
// is waiting. arb_req_out / arb_grant_in let several arbiters be cascaded
// into a tree (tie arb_grant_in to 1 at the root).
//
// Optional feature macro: RR_ARB_BACK2BACK_EN
//   defined   : a releasing owner hands over directly to the next pending
//               requester with no IDLE cycle in between.
//   undefined : one IDLE cycle separates successive owners.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   req          in   [NUM_REQ]  per-requester request level
//   grant        out  [NUM_REQ]  one-hot grant (or zero)
//   grant_idx    out  [IDX_W]    index of current owner
//   arb_req_out  out  1          request to parent, high while owned
//   arb_grant_in in   1          grant from parent
//
// Handshake: a requester holds req high until it sees its grant bit and
// for as long as it wants to keep the grant; dropping req releases it.
// Upwards, arb_req_out is high while this block holds an owner, and the
// owner only counts as granted on cycles where arb_grant_in is also high.
module rr_arbiter_n #(
    parameter int  NUM_REQ  = 8,
    parameter int  MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               arb_req_out,
    input  logic               arb_grant_in
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0]  others;
    logic [IDX_W-1:0]    owner_nxt;
    logic                rel_now;

    // First set bit of r at index >= start, wrapping. The sum is one bit
    // wider than the index so the wrap works for non-power-of-2 NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] idx;
        logic           found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, start} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && r[idx[IDX_W-1:0]]) begin
                rr_pick = idx[IDX_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        others          = req;
        others[owner_q] = 1'b0;
        owner_nxt       = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        // Owner drop and hold expiry give the same next state, so one flag.
        rel_now = !req[owner_q] ||
                  ((hold_cnt_q == HOLD_LAST) && arb_grant_in && (|others));
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d    = rr_pick(req, ptr_q);
                    hold_cnt_d = '0;
                    state_d    = OWNED;
                end
            end
            OWNED: begin
                if (rel_now) begin
                    ptr_d   = owner_nxt;
                    state_d = IDLE;
`ifdef RR_ARB_BACK2BACK_EN
                    if (|others) begin
                        owner_d    = rr_pick(others, owner_nxt);
                        hold_cnt_d = '0;
                        state_d    = OWNED;
                    end
`endif
                end else if (arb_grant_in && (hold_cnt_q != HOLD_LAST)) begin
                    // Parent stalls do not consume hold budget; saturates.
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        grant = '0;
        if ((state_q == OWNED) && arb_grant_in) begin
            grant[owner_q] = 1'b1;
        end
    end

    assign grant_idx   = owner_q;
    assign arb_req_out = (state_q == OWNED);

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Testbench for rr_arbiter_n: main instance NUM_REQ=8/MAX_HOLD=16 and a
// second instance NUM_REQ=5/MAX_HOLD=1 for the non-power-of-2 wrap.
module tb_rr_arbiter_n;

  localparam int N  = 8;
  localparam int MH = 16;
`ifdef RR_ARB_BACK2BACK_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       rqo;
  logic       agi;
  logic [4:0] req5;
  logic [4:0] grant5;
  logic [2:0] idx5;
  logic       rqo5;
  logic       agi5 = 1'b1;

  always #5 clk = ~clk;

  rr_arbiter_n #(.NUM_REQ(8), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_idx(grant_idx),
    .arb_req_out(rqo), .arb_grant_in(agi)
  );

  rr_arbiter_n #(.NUM_REQ(5), .MAX_HOLD(1)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .grant(grant5), .grant_idx(idx5),
    .arb_req_out(rqo5), .arb_grant_in(agi5)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Behavioural view: busy flag, owner, pointer and granted-cycle count.
  int m_busy, m_owner, m_ptr, m_hold;

  logic [11:0] act_q[$];   // observed {arb_req_out, grant_idx, grant}
  logic [11:0] exp_q[$];   // model prediction for the same cycle
  logic [11:0] trace[$];   // copy of observations for scenario analysis
  int run_idx[$], run_len[$], run_gap[$];

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic g);
    logic [7:0] oth;
    oth = r & ~(8'd1 << m_owner);
    if (m_busy == 0) begin
      if (r != 8'd0) begin
        m_owner = first_from(r, m_ptr); m_busy = 1; m_hold = 0;
      end
    end else if (!r[m_owner] || (m_hold == MH - 1 && g && oth != 8'd0)) begin
      m_ptr = (m_owner + 1) % N;
`ifdef RR_ARB_BACK2BACK_EN
      if (oth != 8'd0) begin
        m_owner = first_from(oth, m_ptr); m_hold = 0;
      end else m_busy = 0;
`else
      m_busy = 0;
`endif
    end else if (g && m_hold < MH - 1) begin
      m_hold++;
    end
  endtask

  function automatic logic [11:0] model_out(input logic g);
    logic [7:0] gx;
    logic [31:0] ow;
    ow = m_owner;
    gx = (m_busy != 0 && g) ? (8'd1 << m_owner) : 8'd0;
    return {(m_busy != 0), ow[2:0], gx};
  endfunction

  // ---------------- driver ----------------
  task automatic do_reset();
    rst = 1'b1; req = 8'd0; agi = 1'b1; req5 = 5'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    act_q.delete(); exp_q.delete();
  endtask

  // Drive one cycle, record observed and predicted outputs, advance.
  task automatic cycle(input logic [7:0] r, input logic g);
    req = r; agi = g; #1;
    act_q.push_back({rqo, grant_idx, grant});
    exp_q.push_back(model_out(g));
    @(posedge clk);
    model_step(r, g);
    #1;
  endtask

  // Split the trace into ownership runs: index, granted cycles, idle gap.
  task automatic extract_runs();
    int cur, len, gap, seen;
    run_idx.delete(); run_len.delete(); run_gap.delete();
    cur = -1; len = 0; gap = 0; seen = 0;
    foreach (trace[i]) begin
      if (trace[i][11]) begin
        if (cur != int'(trace[i][10:8]) || (i > 0 && !trace[i-1][11])) begin
          if (cur >= 0) begin run_idx.push_back(cur); run_len.push_back(len); end
          run_gap.push_back(seen ? gap : 0);
          cur = int'(trace[i][10:8]); len = 0; gap = 0; seen = 1;
        end
        if (trace[i][7:0] != 8'd0) len++;
      end else begin
        if (cur >= 0) begin run_idx.push_back(cur); run_len.push_back(len); cur = -1; end
        gap++;
      end
    end
    if (cur >= 0) begin run_idx.push_back(cur); run_len.push_back(len); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] a, e;
    rst = 1'b1; req = 8'd0; agi = 1'b1; req5 = 5'd0;
    #3;
    checks++;
    if ({rqo, grant_idx, grant} !== 12'h000) begin
      errors++; $display("FAIL reset_values: got %h want 000", {rqo, grant_idx, grant});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    act_q.delete(); exp_q.delete();
    cycle(8'h08, 1'b1);
    cycle(8'h08, 1'b1);
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL reset_own3: got %h want %h", a, e); end
    end
    // Async reset mid-cycle while owner=3 is granted.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rqo, grant_idx, grant} !== 12'h000) begin
      errors++; $display("FAIL reset_async: got %h want 000", {rqo, grant_idx, grant});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(8'hFF, 1'b1);
    cycle(8'hFF, 1'b1);
    trace = act_q;
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL reset_repick: got %h want %h", a, e); end
    end
    checks++;
    if (trace[1] !== 12'h801) begin
      errors++; $display("FAIL reset_first_pick: got %h want 801", trace[1]);
    end
  endtask

  task automatic test_rotation();
    logic [11:0] a, e;
    do_reset();
    for (int i = 0; i < 160; i++) cycle(8'hFF, 1'b1);
    trace = act_q;
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL rotation_model: got %h want %h", a, e); end
    end
    extract_runs();
    checks++;
    if (run_idx.size() < 9) begin
      errors++; $display("FAIL rotation_runs: got %0d runs want >=9", run_idx.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (run_idx[k] != k % N) begin
          errors++; $display("FAIL rotation_order[%0d]: got %0d want %0d", k, run_idx[k], k % N);
        end
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (run_len[k] != MH) begin
          errors++; $display("FAIL rotation_hold[%0d]: got %0d want %0d", k, run_len[k], MH);
        end
      end
      for (int k = 1; k < 9; k++) begin
        checks++;
        if (run_gap[k] != GAP) begin
          errors++; $display("FAIL rotation_gap[%0d]: got %0d want %0d", k, run_gap[k], GAP);
        end
      end
    end
  endtask

  task automatic test_single_saturate();
    logic [11:0] a, e;
    int bad;
    do_reset();
    for (int i = 0; i < 101; i++) cycle(8'h04, 1'b1);
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b1);
    cycle(8'hFF, 1'b1);
    cycle(8'hFF, 1'b1);
    trace = act_q;
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL single_model: got %h want %h", a, e); end
    end
    bad = 0;
    for (int i = 1; i <= 100; i++) if (trace[i] !== 12'hA04) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_hold: got %0d bad cycles want 0", bad); end
    checks++;
    if (trace[102][11] !== 1'b0) begin
      errors++; $display("FAIL single_release: got rqo=%b want 0", trace[102][11]);
    end
    checks++;
    if (trace[104] !== 12'hB08) begin
      errors++; $display("FAIL single_ptr3: got %h want b08", trace[104]);
    end
  endtask

  task automatic test_parent_stall();
    logic [11:0] a, e;
    int bad;
    do_reset();
    cycle(8'h20, 1'b1);
    for (int i = 0; i < 40; i++) cycle(8'h21, 1'b0);
    for (int i = 0; i < 30; i++) cycle(8'h21, 1'b1);
    trace = act_q;
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL stall_model: got %h want %h", a, e); end
    end
    bad = 0;
    for (int i = 1; i <= 40; i++) if (trace[i] !== 12'hD00) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    extract_runs();
    checks++;
    if (run_idx.size() < 2 || run_idx[0] != 5 || run_len[0] != MH || run_idx[1] != 0) begin
      errors++;
      $display("FAIL stall_handover: got runs=%0d first idx=%0d len=%0d want idx 5 len %0d then 0",
               run_idx.size(), (run_idx.size() > 0) ? run_idx[0] : -1,
               (run_len.size() > 0) ? run_len[0] : -1, MH);
    end
  endtask

  task automatic test_random();
    logic [11:0] a, e;
    logic [7:0]  r;
    logic        g;
    int          hold_for;
    do_reset();
    r = 8'd0; g = 1'b1; hold_for = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_for == 0) begin
        r = 8'($urandom);
        hold_for = $urandom_range(1, 40);
      end
      hold_for--;
      g = ($urandom_range(0, 3) != 0);
      cycle(r, g);
    end
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL random_model: got %h want %h", a, e); end
    end
  endtask

  task automatic test_nonpow2();
    int exp5_q[$];
    int starts[$];
    logic prev;
    do_reset();
    exp5_q = '{0, 1, 2, 3, 4, 0};
    req5 = 5'h1F;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (!$onehot0(grant5) || (rqo5 && idx5 > 3'd4)) begin
        errors++; $display("FAIL np2_range: got grant=%b idx=%0d", grant5, idx5);
      end
      if (rqo5 && (!prev || starts.size() == 0 || starts[$] != int'(idx5))) starts.push_back(int'(idx5));
      prev = rqo5;
    end
    req5 = 5'd0;
    checks++;
    if (starts.size() < 6) begin
      errors++; $display("FAIL np2_runs: got %0d owners want >=6", starts.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (starts[k] != exp5_q[k]) begin
          errors++; $display("FAIL np2_order[%0d]: got %0d want %0d", k, starts[k], exp5_q[k]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_rotation();
    test_single_saturate();
    test_parent_stall();
    test_random();
    test_nonpow2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
